// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the 2-way set-associative cache controller.
//   - FSM state type and state encodings
//   - address field widths/offsets for the 10-bit byte address
//   - word select / word merge helpers for the 128-bit block
//     (word offset 00 is bits [127:96], 11 is bits [31:0])
package cache_pkg;

  localparam int ADDR_W  = 10;
  localparam int WORD_W  = 32;
  localparam int BLK_W   = 128;
  localparam int OFS_LSB = 2;
  localparam int IDX_LSB = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_COMPARE   = 2'd1;
  localparam state_t S_WRITEBACK = 2'd2;
  localparam state_t S_ALLOCATE  = 2'd3;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0] ofs);
    logic [WORD_W-1:0] w;
    case (ofs)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                input logic [1:0] ofs,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] b;
    b = blk;
    case (ofs)
      2'd0:    b[127:96] = w;
      2'd1:    b[95:64]  = w;
      2'd2:    b[63:32]  = w;
      default: b[31:0]   = w;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: storage for one way of the cache (tag, valid, dirty, data).
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears everything)
//   idx_i           - set index for both the combinational read and the write
//   tag_o/valid_o/dirty_o/data_o - contents of the indexed entry
//   wr_en_i         - write the whole indexed entry; valid is set on every write
//   wr_tag_i, wr_dirty_i, wr_data_i - entry contents to write
module cache_way_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 2,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = ADDR_W - IDX_LSB - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [BLK_W-1:0] data_o,
  input  logic             wr_en_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             wr_dirty_i,
  input  logic [BLK_W-1:0] wr_data_i
);

  logic [TAG_W-1:0]    tag_q   [NUM_SETS];
  logic [BLK_W-1:0]    data_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else if (wr_en_i) begin
      tag_q[idx_i]   <= wr_tag_i;
      data_q[idx_i]  <= wr_data_i;
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

endmodule

// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: write-back, write-allocate, 2-way set-associative cache
// controller between a CPU word port and a 128-bit-block main memory.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata - CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready, cpu_hit - load data, completion pulse, first-lookup hit
//   mem_rw                      - one-cycle write strobe at the end of a write-back
//   mem_addr, mem_wdata         - block address / write-back block (held when unused)
//   mem_rdata                   - block read data, combinational from mem_addr
module cache_ctrl_2way
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 2,
  parameter int MEM_LAT  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [9:0]   cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic         cpu_hit,
  output logic         mem_rw,
  output logic [9:0]   mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:2]         addr_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic               victim_q;
  logic               replay_q;
  logic [NUM_SETS-1:0] lru_q;
  logic [31:0]        rdata_q;
  logic               ready_q;
  logic               hit_q;
  logic [9:0]         maddr_q;
  logic [127:0]       mwdata_q;

  // Byte-lane bits are not part of the word access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       ofs;
  assign idx = addr_q[IDX_LSB +: IDX_W];
  assign tag = addr_q[9 -: TAG_W];
  assign ofs = addr_q[OFS_LSB +: 2];

  logic [TAG_W-1:0] tag0, tag1, wr_tag;
  logic             v0, v1, d0, d1, wr_dirty, wr_en0, wr_en1;
  logic [BLK_W-1:0] data0, data1, wr_data;

  cache_way_array #(.NUM_SETS(NUM_SETS)) u_way0 (
    .clk(clk), .reset(reset), .idx_i(idx),
    .tag_o(tag0), .valid_o(v0), .dirty_o(d0), .data_o(data0),
    .wr_en_i(wr_en0), .wr_tag_i(wr_tag), .wr_dirty_i(wr_dirty), .wr_data_i(wr_data)
  );

  cache_way_array #(.NUM_SETS(NUM_SETS)) u_way1 (
    .clk(clk), .reset(reset), .idx_i(idx),
    .tag_o(tag1), .valid_o(v1), .dirty_o(d1), .data_o(data1),
    .wr_en_i(wr_en1), .wr_tag_i(wr_tag), .wr_dirty_i(wr_dirty), .wr_data_i(wr_data)
  );

  logic             hit0, hit1, hit_any;
  logic [BLK_W-1:0] hit_blk;
  assign hit0    = v0 && (tag0 == tag);
  assign hit1    = v1 && (tag1 == tag);
  assign hit_any = hit0 || hit1;
  assign hit_blk = hit1 ? data1 : data0;

  // Victim choice: an empty way first (way0 before way1), else the LRU way.
  logic             vict, vict_v, vict_d;
  logic [TAG_W-1:0] vict_tag;
  logic [BLK_W-1:0] vict_blk;
  assign vict     = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[idx]);
  assign vict_v   = vict ? v1 : v0;
  assign vict_d   = vict ? d1 : d0;
  assign vict_tag = vict ? tag1 : tag0;
  assign vict_blk = vict ? data1 : data0;

  logic cnt_last;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Next state, phase counter and the shared way write port.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_tag   = tag;
    wr_dirty = 1'b0;
    wr_data  = mem_rdata;
    case (state_q)
      S_IDLE: begin
        // Ignore a request still held during the ready pulse cycle.
        if (cpu_req && !ready_q) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit_any) begin
          state_d = S_IDLE;
          if (we_q) begin
            wr_en0   = hit0;
            wr_en1   = hit1;
            wr_dirty = 1'b1;
            wr_data  = put_word(hit_blk, ofs, wdata_q);
          end
        end else if (vict_v && vict_d) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (cnt_last) state_d = S_ALLOCATE;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        if (cnt_last) begin
          state_d = S_COMPARE;
          wr_en0  = !victim_q;
          wr_en1  = victim_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      victim_q <= 1'b0;
      replay_q <= 1'b0;
      lru_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      hit_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req && !ready_q) begin
            addr_q   <= cpu_addr[9:2];
            we_q     <= cpu_we;
            wdata_q  <= cpu_wdata;
            replay_q <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (hit_any) begin
            ready_q    <= 1'b1;
            hit_q      <= !replay_q;
            lru_q[idx] <= !hit1;
            if (!we_q) rdata_q <= get_word(hit_blk, ofs);
          end else begin
            victim_q <= vict;
            if (vict_v && vict_d) begin
              maddr_q  <= {vict_tag, idx, 4'b0000};
              mwdata_q <= vict_blk;
            end else begin
              maddr_q <= {tag, idx, 4'b0000};
            end
          end
        end
        S_WRITEBACK: begin
          if (cnt_last) maddr_q <= {tag, idx, 4'b0000};
        end
        default: begin
          if (cnt_last) replay_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_hit   = hit_q;
  assign mem_rw    = (state_q == S_WRITEBACK) && cnt_last;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb_cache_ctrl_2way: self-checking bench for cache_ctrl_2way with a
// behavioural block memory (word i preloaded to 32'hA000_0000 + i) and a
// queue of expected completions (latency, hit flag, load data).
module tb_cache_ctrl_2way;

  localparam int NUM_SETS = 2;
  localparam int MEM_LAT  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [9:0]   cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_hit;
  logic         mem_rw;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;

  cache_ctrl_2way #(.NUM_SETS(NUM_SETS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: 256 words, 4 words per block, word offset 0 in the top lane.
  logic [31:0] mem [256];
  int          wb_cnt = 0;
  logic [9:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;

  always_comb begin
    int b;
    b = int'(mem_addr[9:4]);
    mem_rdata = {mem[b*4], mem[b*4+1], mem[b*4+2], mem[b*4+3]};
  end

  always @(negedge clk) begin
    if (mem_rw === 1'b1) begin
      int b;
      b = int'(mem_addr[9:4]);
      wb_cnt  = wb_cnt + 1;
      wb_addr = mem_addr;
      wb_data = mem_wdata;
      mem[b*4]   = mem_wdata[127:96];
      mem[b*4+1] = mem_wdata[95:64];
      mem[b*4+2] = mem_wdata[63:32];
      mem[b*4+3] = mem_wdata[31:0];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] rdata;
    logic        hit;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst ready", 128'(cpu_ready), 128'(0));
    chk("rst hit",   128'(cpu_hit),   128'(0));
    chk("rst rdata", 128'(cpu_rdata), 128'(0));
    chk("rst mem_rw", 128'(mem_rw),   128'(0));
    chk("rst mem_addr", 128'(mem_addr), 128'(0));
    chk("rst mem_wdata", mem_wdata, 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One CPU access: the expectation is queued when the request is driven and
  // popped when cpu_ready arrives. Latency counts edges after the sampling edge.
  task automatic access(input string tag, input logic we, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_hit, input int exp_lat);
    exp_t e;
    int   n;
    logic got;
    e.tag = tag; e.we = we; e.rdata = exp_rd; e.hit = exp_hit; e.lat = exp_lat;
    exp_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (cpu_ready === 1'b1) got = 1'b1;
    end
    cpu_req = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("%s ready seen", e.tag), 128'(got), 128'(1));
    chk($sformatf("%s latency", e.tag), 128'(n), 128'(e.lat));
    chk($sformatf("%s hit", e.tag), 128'(cpu_hit), 128'(e.hit));
    if (!e.we) chk($sformatf("%s rdata", e.tag), 128'(cpu_rdata), 128'(e.rdata));
    @(posedge clk);
  endtask

  initial begin
    int wb0;
    int rdy;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    // 1: cold miss then hit
    do_reset();
    access("t1 miss", 1'b0, 10'h010, 32'h0, 32'hA000_0004, 1'b0, 2 + MEM_LAT);
    chk("t1 no mem_rw", 128'(wb_cnt), 128'(0));
    access("t1 hit", 1'b0, 10'h010, 32'h0, 32'hA000_0004, 1'b1, 1);

    // 2: store hit, read back, memory untouched
    access("t2 store", 1'b1, 10'h014, 32'hDEAD_BEEF, 32'h0, 1'b1, 1);
    access("t2 load", 1'b0, 10'h014, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
    chk("t2 mem word5", 128'(mem[5]), 128'(32'hA000_0005));
    chk("t2 no mem_rw", 128'(wb_cnt), 128'(0));

    // 3: dirty eviction in set 0
    wb0 = wb_cnt;
    access("t3 store", 1'b1, 10'h000, 32'h1234_5678, 32'h0, 1'b0, 2 + MEM_LAT);
    access("t3 ld020", 1'b0, 10'h020, 32'h0, 32'hA000_0008, 1'b0, 2 + MEM_LAT);
    access("t3 ld040", 1'b0, 10'h040, 32'h0, 32'hA000_0010, 1'b0, 2 + 2*MEM_LAT);
    chk("t3 wb count", 128'(wb_cnt - wb0), 128'(1));
    chk("t3 wb addr", 128'(wb_addr), 128'(10'h000));
    chk("t3 wb word0", 128'(wb_data[127:96]), 128'(32'h1234_5678));

    // 4: LRU victim selection (memory word 0 now holds the written-back store)
    do_reset();
    wb0 = wb_cnt;
    access("t4 ld000", 1'b0, 10'h000, 32'h0, 32'h1234_5678, 1'b0, 2 + MEM_LAT);
    access("t4 ld020", 1'b0, 10'h020, 32'h0, 32'hA000_0008, 1'b0, 2 + MEM_LAT);
    access("t4 ld000 hit", 1'b0, 10'h000, 32'h0, 32'h1234_5678, 1'b1, 1);
    access("t4 ld040", 1'b0, 10'h040, 32'h0, 32'hA000_0010, 1'b0, 2 + MEM_LAT);
    chk("t4 no mem_rw", 128'(wb_cnt - wb0), 128'(0));
    access("t4 ld000 again", 1'b0, 10'h000, 32'h0, 32'h1234_5678, 1'b1, 1);

    // 5: reset during ALLOCATE abandons the access
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h030; cpu_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5 alloc addr", 128'(mem_addr), 128'(10'h030));
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    rdy = 0;
    @(posedge clk);
    #1;
    if (cpu_ready === 1'b1) rdy++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ready === 1'b1) rdy++;
    end
    chk("t5 no ready", 128'(rdy), 128'(0));
    access("t5 reissue", 1'b0, 10'h030, 32'h0, 32'hA000_000C, 1'b0, 2 + MEM_LAT);

    // 6: set 1 survives evictions in set 0
    do_reset();
    access("t6 ld010", 1'b0, 10'h010, 32'h0, 32'hA000_0004, 1'b0, 2 + MEM_LAT);
    access("t6 store", 1'b1, 10'h000, 32'h1234_5678, 32'h0, 1'b0, 2 + MEM_LAT);
    access("t6 ld020", 1'b0, 10'h020, 32'h0, 32'hA000_0008, 1'b0, 2 + MEM_LAT);
    access("t6 ld040", 1'b0, 10'h040, 32'h0, 32'hA000_0010, 1'b0, 2 + 2*MEM_LAT);
    access("t6 ld010 hit", 1'b0, 10'h010, 32'h0, 32'hA000_0004, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
